// File: rtl/tiny_proc_loader.sv
// Board-side loader for the tiny processor demo: resets the processor, shifts the
// program image in serially on a divided clock, then lets it run until done.
module tiny_proc_loader #(
   parameter int MEM_DEPTH  = 16,
   parameter int WORD_W     = 8,
   parameter int CLK_DIV    = 2,
   parameter int RST_CYCLES = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       drive,
   input  logic       done_in,
   output logic       sclk_out,
   output logic       rst_n_out,
   output logic       mosi_out,
   output logic [1:0] mode_out
);
   localparam int TOTAL = MEM_DEPTH * WORD_W;
   localparam int CW    = $clog2(TOTAL) + 1;
   localparam int AW    = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
   localparam int BW    = (WORD_W > 1) ? $clog2(WORD_W) : 1;
   localparam int DW    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

   localparam logic [2:0] S_IDLE     = 3'd0;
   localparam logic [2:0] S_PROC_RST = 3'd1;
   localparam logic [2:0] S_LOAD     = 3'd2;
   localparam logic [2:0] S_RUN      = 3'd3;
   localparam logic [2:0] S_DONE     = 3'd4;

   localparam logic [1:0] MODE_IDLE = 2'b00;
   localparam logic [1:0] MODE_LOAD = 2'b01;
   localparam logic [1:0] MODE_RUN  = 2'b10;

   // Program image, preloaded hierarchically by the bench or by a synthesis init file.
   logic [WORD_W-1:0] mem [0:MEM_DEPTH-1];

   logic [2:0]    state_q, state_d;
   logic [DW-1:0] div_q, div_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [AW-1:0] word_q, word_d;
   logic [BW-1:0] bpos_q, bpos_d;
   logic          done_q, done_d;
   logic          sclk_q, sclk_d;
   logic          rst_n_q, rst_n_d;
   logic          mosi_q, mosi_d;
   logic [1:0]    mode_q, mode_d;
   logic          tick, rise, fall;

   always_comb begin
      state_d = state_q;
      div_d   = div_q;
      cnt_d   = cnt_q;
      word_d  = word_q;
      bpos_d  = bpos_q;
      sclk_d  = sclk_q;
      rst_n_d = rst_n_q;
      mosi_d  = mosi_q;
      mode_d  = mode_q;
      done_d  = (state_q == S_RUN) & done_in;
      tick    = (div_q == DW'(CLK_DIV - 1));
      rise    = tick & ~sclk_q;
      fall    = tick & sclk_q;

      if (state_q == S_PROC_RST || state_q == S_LOAD || state_q == S_RUN) begin
         div_d = tick ? '0 : div_q + 1'b1;
         if (tick) sclk_d = ~sclk_q;
      end

      case (state_q)
         S_IDLE: begin
            sclk_d  = 1'b0;
            rst_n_d = 1'b0;
            mosi_d  = 1'b0;
            mode_d  = MODE_IDLE;
            div_d   = '0;
            cnt_d   = '0;
            if (drive) state_d = S_PROC_RST;
         end
         S_PROC_RST: begin
            if (rise) cnt_d = cnt_q + 1'b1;
            if (fall && cnt_q == CW'(RST_CYCLES)) begin
               state_d = S_LOAD;
               rst_n_d = 1'b1;
               mode_d  = MODE_LOAD;
               mosi_d  = mem[{AW{1'b0}}][WORD_W-1];
               cnt_d   = '0;
               word_d  = '0;
               bpos_d  = BW'(WORD_W - 1);
            end
         end
         S_LOAD: begin
            // cnt_q counts bits already sampled; on a fall present the next one.
            if (rise) cnt_d = cnt_q + 1'b1;
            if (fall) begin
               if (cnt_q == CW'(TOTAL)) begin
                  state_d = S_RUN;
                  mode_d  = MODE_RUN;
                  mosi_d  = 1'b0;
               end else begin
                  if (bpos_q == '0) begin
                     word_d = word_q + 1'b1;
                     bpos_d = BW'(WORD_W - 1);
                  end else begin
                     bpos_d = bpos_q - 1'b1;
                  end
                  mosi_d = mem[word_d][bpos_d];
               end
            end
         end
         S_RUN: begin
            if (fall && done_q) begin
               state_d = S_DONE;
               mode_d  = MODE_IDLE;
            end
         end
         S_DONE: begin
            sclk_d  = 1'b0;
            rst_n_d = 1'b1;
            mosi_d  = 1'b0;
            mode_d  = MODE_IDLE;
            div_d   = '0;
            if (!drive) begin
               state_d = S_IDLE;
               rst_n_d = 1'b0;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         div_q   <= '0;
         cnt_q   <= '0;
         word_q  <= '0;
         bpos_q  <= '0;
         done_q  <= 1'b0;
         sclk_q  <= 1'b0;
         rst_n_q <= 1'b0;
         mosi_q  <= 1'b0;
         mode_q  <= MODE_IDLE;
      end else begin
         state_q <= state_d;
         div_q   <= div_d;
         cnt_q   <= cnt_d;
         word_q  <= word_d;
         bpos_q  <= bpos_d;
         done_q  <= done_d;
         sclk_q  <= sclk_d;
         rst_n_q <= rst_n_d;
         mosi_q  <= mosi_d;
         mode_q  <= mode_d;
      end
   end

   assign sclk_out  = sclk_q;
   assign rst_n_out = rst_n_q;
   assign mosi_out  = mosi_q;
   assign mode_out  = mode_q;
endmodule

// File: tb/tb_tiny_proc_loader.sv
// Bench for tiny_proc_loader: table of scenarios plus random images, each load
// checked against a bitstream queue built from the bench's own copy of the image.
module tb_tiny_proc_loader;
   localparam int MEM_DEPTH  = 16;
   localparam int WORD_W     = 8;
   localparam int CLK_DIV    = 2;
   localparam int RST_CYCLES = 4;
   localparam int TOTAL      = MEM_DEPTH * WORD_W;

   logic       clk = 1'b0;
   logic       rst, drive, done_in;
   logic       sclk_out, rst_n_out, mosi_out;
   logic [1:0] mode_out;

   int errors = 0;
   int checks = 0;
   logic [WORD_W-1:0] tb_mem [MEM_DEPTH];
   logic exp_q [$];

   typedef struct {
      logic [7:0]  m0;
      logic [7:0]  m1;
      logic [7:0]  fill;
      int          run_periods;
      bit          drop;
      bit          early_done;
      int          abort_at;
      logic [15:0] exp_head;
   } vec_t;

   tiny_proc_loader #(
      .MEM_DEPTH(MEM_DEPTH), .WORD_W(WORD_W), .CLK_DIV(CLK_DIV), .RST_CYCLES(RST_CYCLES)
   ) dut (
      .clk(clk), .rst(rst), .drive(drive), .done_in(done_in),
      .sclk_out(sclk_out), .rst_n_out(rst_n_out), .mosi_out(mosi_out), .mode_out(mode_out)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic load_mem(input logic [7:0] m0, input logic [7:0] m1, input logic [7:0] fill);
      for (int i = 0; i < MEM_DEPTH; i++) begin
         tb_mem[i] = (i == 0) ? m0 : (i == 1) ? m1 : fill;
         dut.mem[i] = tb_mem[i];
      end
   endtask

   // One full drive cycle: reset phase, load, run, done, release.
   task automatic run_once(input logic [15:0] exp_head, input int run_periods, input bit drop,
                           input bit early_done, input int abort_at);
      int cyc, rst_rises, load_rises, run_rises, last_rise, done_cyc, bad;
      logic prev_sclk, prev_mosi, exp_bit;
      logic [15:0] head;
      bit seen_load, seen_run, finished;
      exp_q.delete();
      for (int w = 0; w < MEM_DEPTH; w++)
         for (int b = WORD_W - 1; b >= 0; b--) exp_q.push_back(tb_mem[w][b]);
      rst_rises = 0; load_rises = 0; run_rises = 0; last_rise = -1; done_cyc = -1;
      seen_load = 0; seen_run = 0; finished = 0; head = '0;
      prev_sclk = sclk_out; prev_mosi = mosi_out;
      @(negedge clk);
      drive = 1'b1;
      done_in = early_done;
      for (cyc = 0; cyc < 3000 && !finished; cyc++) begin
         @(posedge clk); #1;
         if (!prev_sclk && sclk_out) begin
            if (last_rise >= 0) check("sclk_period", cyc - last_rise, 2 * CLK_DIV);
            last_rise = cyc;
            if (mode_out == 2'b00) begin
               check("rst_phase_rst_n", rst_n_out, 0);
               rst_rises++;
            end else if (mode_out == 2'b01) begin
               check("mosi_stable", mosi_out, prev_mosi);
               if (exp_q.size() == 0) check("load_overrun", load_rises + 1, TOTAL);
               else begin
                  exp_bit = exp_q.pop_front();
                  check("load_bit", mosi_out, exp_bit);
               end
               load_rises++;
               if (load_rises <= 16) head = {head[14:0], mosi_out};
               if (load_rises == 16) check("load_head16", head, exp_head);
               if (drop && load_rises == 40) drive = 1'b0;
               if (abort_at > 0 && load_rises == abort_at) begin
                  #2 rst = 1'b1;
                  #1 check("abort_async_reset", {sclk_out, rst_n_out, mosi_out, mode_out}, 0);
                  drive = 1'b0;
                  done_in = 1'b0;
                  repeat (3) @(posedge clk);
                  #1 check("abort_held_reset", {sclk_out, rst_n_out, mosi_out, mode_out}, 0);
                  @(negedge clk) rst = 1'b0;
                  return;
               end
            end else if (mode_out == 2'b10) begin
               run_rises++;
               if (run_rises == run_periods && done_cyc < 0) begin
                  done_in = 1'b1;
                  done_cyc = cyc;
               end
            end
         end
         if (mode_out == 2'b01 && !seen_load) begin
            seen_load = 1;
            check("rst_rises", rst_rises, RST_CYCLES);
            check("load_entry_on_fall", {prev_sclk, sclk_out, rst_n_out}, 3'b101);
         end
         if (mode_out == 2'b10 && !seen_run) begin
            seen_run = 1;
            check("load_rises", load_rises, TOTAL);
            check("run_entry", {rst_n_out, mosi_out, prev_sclk, sclk_out}, 4'b1010);
            done_in = 1'b0;
            if (drop) drive = 1'b1;
            if (run_periods == 0) begin
               done_in = 1'b1;
               done_cyc = cyc;
            end
         end
         if (done_cyc >= 0 && mode_out == 2'b00 && !sclk_out) begin
            check("done_latency_ok", int'((cyc - done_cyc) <= 2 * CLK_DIV + 2), 1);
            finished = 1;
         end
         prev_sclk = sclk_out;
         prev_mosi = mosi_out;
      end
      check("run_finished", finished, 1);
      check("run_rises", run_rises >= run_periods, 1);
      bad = 0;
      repeat (100) begin
         @(posedge clk); #1;
         if ({sclk_out, mode_out, mosi_out, rst_n_out} != 5'b00001) bad++;
      end
      check("done_hold_bad_cycles", bad, 0);
      @(negedge clk) drive = 1'b0;
      done_in = 1'b0;
      @(posedge clk); #1;
      check("idle_after_release", {rst_n_out, mode_out, sclk_out}, 0);
      repeat (2) @(posedge clk);
   endtask

   initial begin
      vec_t vecs [5];
      int bad;
      logic [15:0] rnd_head;
      vecs[0] = '{8'hA5, 8'h3C, 8'h00, 50, 1'b0, 1'b0, 0,  16'hA53C};
      vecs[1] = '{8'hFF, 8'h00, 8'hFF, 3,  1'b1, 1'b1, 0,  16'hFF00};
      vecs[2] = '{8'hA5, 8'h3C, 8'h00, 50, 1'b0, 1'b0, 40, 16'hA53C};
      vecs[3] = '{8'hA5, 8'h3C, 8'h00, 5,  1'b0, 1'b0, 0,  16'hA53C};
      vecs[4] = '{8'h81, 8'h7E, 8'h55, 1,  1'b0, 1'b0, 0,  16'h817E};

      rst = 1'b1; drive = 1'b0; done_in = 1'b0;
      bad = 0;
      repeat (10) begin
         @(posedge clk); #1;
         if ({sclk_out, rst_n_out, mosi_out, mode_out} != 5'b0) bad++;
      end
      check("reset_hold", bad, 0);
      @(negedge clk) rst = 1'b0;
      bad = 0;
      repeat (5) begin
         @(posedge clk); #1;
         if ({sclk_out, rst_n_out, mosi_out, mode_out} != 5'b0) bad++;
      end
      check("idle_after_reset", bad, 0);

      foreach (vecs[i]) begin
         load_mem(vecs[i].m0, vecs[i].m1, vecs[i].fill);
         run_once(vecs[i].exp_head, vecs[i].run_periods, vecs[i].drop,
                  vecs[i].early_done, vecs[i].abort_at);
      end

      for (int r = 0; r < 3; r++) begin
         for (int i = 0; i < MEM_DEPTH; i++) begin
            tb_mem[i] = 8'($urandom_range(0, 255));
            dut.mem[i] = tb_mem[i];
         end
         rnd_head = {tb_mem[0], tb_mem[1]};
         run_once(rnd_head, $urandom_range(0, 8), 1'b0, 1'b0, 0);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
